bin_to_xs3_seq: RTL and testbench
=================================

# bin_to_xs3_seq

Sequential, parametrised binary-to-excess-3 converter for multi-digit values. It uses the shift-and-add-3 (double-dabble) method to produce `NDIG` decimal digits from an `IN_W`-bit unsigned input. A per-transaction mode selects excess-3 or plain BCD output. It sits between binary datapaths and decimal display/encoding stages, with valid/ready handshakes on both sides.

## Interface
- `IN_W`, 8: binary input width, ≥2.
- `NDIG`, 3: output decimal digits, ≥1; output width is `4*NDIG`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `in_data` and `in_mode` are valid.
- `in_ready` output 1: block can accept; high only in IDLE.
- `in_data` input `IN_W`: unsigned binary value.
- `in_mode` input 1: 1 = excess-3 output, 0 = BCD output.
- `out_valid` output 1: result is valid; high only in DONE.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output `4*NDIG`: digit k in bits [4k+3:4k], least significant digit at k=0.
- `out_ovf` output 1: present only with `BIN2XS3_OVF_EN`.

## Operation
- States: IDLE → SHIFT → ADJ → DONE → IDLE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid & in_ready`: load `in_data` into the shift register, clear the digit register, latch `in_mode`, set the bit counter to `IN_W`, go to SHIFT.
- **SHIFT**, one bit per cycle:
  - Every digit ≥5 gets +3.
  - Then shift {digits, shift register} left by 1 and decrement the counter.
  - After `IN_W` cycles, go to ADJ.
- **ADJ**, one cycle:
  - `out_data` ← digits + 4'd3 per digit if the latched mode is 1, else digits unchanged.
  - Digits are always ≤9, so each excess-3 digit is ≤12 and there is no inter-digit carry.
  - Go to DONE.
- **DONE**: `out_valid`=1 and `out_data` held stable until `out_ready`=1; then return to IDLE.
- Overflow (value ≥10^NDIG): the bit shifted out of the top digit is discarded, so the result equals value mod 10^NDIG, then gets the mode encoding.
- `in_valid` is ignored outside IDLE. `in_data` and `in_mode` changes after acceptance have no effect.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_ovf`=0, counter=0.
- Latency: acceptance edge E, then `out_valid` rises after edge E+`IN_W`+1.
- Throughput: one conversion per `IN_W`+3 cycles minimum, counting the DONE cycle and the IDLE cycle. There is no combinational path from `out_ready` to `in_ready`.
- `out_valid` must not drop without `out_ready`, and `out_data` must not change while `out_valid`=1.
- Asserting `rst_n` low in any state returns to reset values immediately. A partial conversion is discarded and no output is produced.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `BIN2XS3_OVF_EN`.
- **Defined**:
  - Port `out_ovf` exists.
  - It is set in SHIFT if any 1 bit leaves the top digit, and cleared on acceptance.
  - It is valid with `out_valid`.
  - `out_data` is still the mod-10^NDIG result.
- **Undefined**: no `out_ovf` port and no overflow logic; overflow is silent truncation.

## Structure
- Package `bin2xs3_pkg` contains:
  - the state typedef (IDLE, SHIFT, ADJ, DONE);
  - constant `XS3_BIAS` = 4'd3;
  - constant `DABBLE_THR` = 4'd5.
- Sub-module `dabble_cell`: 4-bit combinational "add 3 if ≥5" cell, instantiated `NDIG` times by generate.
- Counter width is $clog2(`IN_W`+1).

## Test plan
Unless stated otherwise, `IN_W`=8 and `NDIG`=3.
- `in_data`=255, mode=1 → `out_data`=12'h588, `out_valid` after exactly 9 edges from acceptance.
- `in_data`=0, mode=1 → 12'h333; `in_data`=0, mode=0 → 12'h000; `in_data`=99, mode=0 → 12'h099.
- Backpressure: `in_data`=128, mode=1, `out_ready` held low 5 cycles:
  - `out_data`=12'h45B is stable and `out_valid` stays high;
  - `in_ready`=0 throughout, and an `in_valid` pulse is ignored;
  - the result is released on the `out_ready` edge.
- Reset mid-conversion, `rst_n` low at SHIFT cycle 4 → all outputs go to reset values asynchronously; a new conversion of 37, mode=0, then gives 12'h037.
- Overflow, with `NDIG`=2 and `BIN2XS3_OVF_EN` defined: `in_data`=200, mode=1 → `out_data`=8'h33, `out_ovf`=1; a next input of 42 → 8'h75, `out_ovf`=0.
- Back-to-back: `in_valid` held high with 10 then 11, mode=1 → results 12'h343 and 12'h344 in order, second acceptance exactly one cycle after the first output handshake.

Source files
------------

// File: rtl/bin2xs3_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bin2xs3_pkg
//  Brief    : Shared types and constants for the binary-to-excess-3 converter.
//  Revision : 1.0 - initial release
// ============================================================================
package bin2xs3_pkg;

    // Conversion controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ADJ   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Offset added to each BCD digit to form its excess-3 code
    localparam logic [3:0] XS3_BIAS   = 4'd3;
    // Digits at or above this value are corrected before the next doubling
    localparam logic [3:0] DABBLE_THR = 4'd5;

endpackage : bin2xs3_pkg
`default_nettype wire

// File: rtl/bin_to_xs3_seq_dabble_cell.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dabble_cell
//  Brief    : One-digit double-dabble correction: adds 3 when digit >= 5 so
//             that the following left shift carries correctly into the next
//             decimal digit.
//  Revision : 1.0 - initial release
// ============================================================================
module dabble_cell
    import bin2xs3_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    localparam logic [3:0] c_DABBLE_ADD = 4'd3;

    // Pure combinational correction of a single BCD digit
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= DABBLE_THR) begin
            o_digit = i_digit + c_DABBLE_ADD;
        end
    end

endmodule : dabble_cell
`default_nettype wire

// File: rtl/bin_to_xs3_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bin_to_xs3_seq
//  Brief    : Sequential IN_W-bit binary to NDIG-digit excess-3 / BCD
//             converter using shift-and-add-3, valid/ready on both sides.
//             Optional macro BIN2XS3_OVF_EN adds the out_ovf flag.
//  Revision : 1.0 - initial release
// ============================================================================
module bin_to_xs3_seq
    import bin2xs3_pkg::*;
#(
    parameter int IN_W = 8,
    parameter int NDIG = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_data,
    input  logic                in_mode,
    output logic                out_valid,
    input  logic                out_ready,
`ifdef BIN2XS3_OVF_EN
    output logic                out_ovf,
`endif
    output logic [4*NDIG-1:0]   out_data
);

    localparam int c_CNT_W = $clog2(IN_W + 1);
    localparam int c_DW    = 4 * NDIG;

    state_t              r_state_q, w_state_d;
    logic [IN_W-1:0]     r_sr_q, w_sr_d;
    logic [c_DW-1:0]     r_dig_q, w_dig_d;
    logic                r_mode_q, w_mode_d;
    logic [c_CNT_W-1:0]  r_cnt_q, w_cnt_d;
    logic [c_DW-1:0]     r_out_data_q, w_out_data_d;

    logic [c_DW-1:0]     w_dig_adj;
    logic [c_DW-1:0]     w_dig_shift;
    logic [c_DW-1:0]     w_dig_xs3;

    // Per-digit add-3 correction and excess-3 biasing
    for (genvar k = 0; k < NDIG; k++) begin : g_digit
        dabble_cell u_cell (
            .i_digit (r_dig_q[4*k +: 4]),
            .o_digit (w_dig_adj[4*k +: 4])
        );
        assign w_dig_xs3[4*k +: 4] = r_dig_q[4*k +: 4] + XS3_BIAS;
    end

    // Bit leaving the top digit is dropped: result wraps modulo 10^NDIG
    assign w_dig_shift = (w_dig_adj << 1) | {{(c_DW-1){1'b0}}, r_sr_q[IN_W-1]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            IDLE:    if (in_valid)             w_state_d = SHIFT;
            SHIFT:   if (r_cnt_q <= c_CNT_W'(1)) w_state_d = ADJ;
            ADJ:                               w_state_d = DONE;
            DONE:    if (out_ready)            w_state_d = IDLE;
            default:                           w_state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state only
    always_comb begin
        in_ready  = (r_state_q == IDLE);
        out_valid = (r_state_q == DONE);
        out_data  = r_out_data_q;
    end

    // Datapath next values: load, shift-and-add, final mode encoding
    always_comb begin
        w_sr_d       = r_sr_q;
        w_dig_d      = r_dig_q;
        w_mode_d     = r_mode_q;
        w_cnt_d      = r_cnt_q;
        w_out_data_d = r_out_data_q;
        case (r_state_q)
            IDLE: begin
                if (in_valid) begin
                    w_sr_d   = in_data;
                    w_dig_d  = '0;
                    w_mode_d = in_mode;
                    w_cnt_d  = c_CNT_W'(IN_W);
                end
            end
            SHIFT: begin
                w_sr_d  = r_sr_q << 1;
                w_dig_d = w_dig_shift;
                w_cnt_d = r_cnt_q - c_CNT_W'(1);
            end
            ADJ: begin
                // Digits never exceed 9, so biasing cannot carry between digits
                w_out_data_d = r_mode_q ? w_dig_xs3 : r_dig_q;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr_q       <= '0;
            r_dig_q      <= '0;
            r_mode_q     <= 1'b0;
            r_cnt_q      <= '0;
            r_out_data_q <= '0;
        end else begin
            r_sr_q       <= w_sr_d;
            r_dig_q      <= w_dig_d;
            r_mode_q     <= w_mode_d;
            r_cnt_q      <= w_cnt_d;
            r_out_data_q <= w_out_data_d;
        end
    end

`ifdef BIN2XS3_OVF_EN
    logic r_ovf_q, w_ovf_d;

    // Sticky overflow: any 1 shifted out of the top digit during a conversion
    always_comb begin
        w_ovf_d = r_ovf_q;
        if (r_state_q == IDLE && in_valid) begin
            w_ovf_d = 1'b0;
        end else if (r_state_q == SHIFT && w_dig_adj[c_DW-1]) begin
            w_ovf_d = 1'b1;
        end
    end

    // Overflow flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_q <= 1'b0;
        end else begin
            r_ovf_q <= w_ovf_d;
        end
    end

    assign out_ovf = r_ovf_q;
`endif

endmodule : bin_to_xs3_seq
`default_nettype wire

// File: tb/tb_bin_to_xs3_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bin_to_xs3_seq
//  Brief    : Self-checking bench for bin_to_xs3_seq (NDIG=3 main instance,
//             NDIG=2 instance for wrap-around / overflow behaviour).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_xs3_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Main instance, IN_W=8, NDIG=3
    logic        in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, out_valid, out_ovf;
    logic [11:0] out_data;

    // Secondary instance, IN_W=8, NDIG=2
    logic        b_in_valid = 1'b0, b_in_mode = 1'b0, b_out_ready = 1'b0;
    logic [7:0]  b_in_data = '0;
    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [7:0]  b_out_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifndef BIN2XS3_OVF_EN
    assign out_ovf   = 1'b0;
    assign b_out_ovf = 1'b0;
`endif

    bin_to_xs3_seq #(.IN_W(8), .NDIG(3)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef BIN2XS3_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .out_data  (out_data)
    );

    bin_to_xs3_seq #(.IN_W(8), .NDIG(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_mode   (b_in_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
`ifdef BIN2XS3_OVF_EN
        .out_ovf   (b_out_ovf),
`endif
        .out_data  (b_out_data)
    );

    // Reference: decimal digits of (v mod 10^ndig), each optionally +3
    function automatic logic [15:0] ref_conv(input int v, input bit m, input int ndig);
        int p;
        int r;
        p = 1;
        r = 0;
        for (int i = 0; i < ndig; i++) p = p * 10;
        v = v % p;
        for (int k = 0; k < ndig; k++) begin
            r = r + (((v % 10) + (m ? 3 : 0)) << (4 * k));
            v = v / 10;
        end
        return 16'(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One transaction on the main instance; hold = cycles of backpressure
    task automatic do_conv(input logic [7:0] d, input logic m, input int hold,
                           output logic [11:0] res, output int lat);
        int n;
        @(negedge clk);
        in_data = d; in_mode = m; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        // Scramble inputs after acceptance; they must not matter
        in_valid = 1'b0; in_data = 8'($urandom); in_mode = ~m;
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); lat++; #1; end
        res = out_data;
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin in_valid = 1'b1; in_data = 8'd7; end
            else in_valid = 1'b0;
            @(posedge clk); #1;
            check("bp_valid",    {31'd0, out_valid}, 32'd1);
            check("bp_data",     {20'd0, out_data},  {20'd0, res});
            check("bp_in_ready", {31'd0, in_ready},  32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", {31'd0, out_valid}, 32'd0);
        check("release_ready", {31'd0, in_ready},  32'd1);
        @(posedge clk); #1;
        check("idle_stays", {31'd0, in_ready}, 32'd1);
    endtask

    // One transaction on the NDIG=2 instance
    task automatic do_conv2(input logic [7:0] d, input logic m,
                            output logic [7:0] res, output logic ovf);
        int n;
        @(negedge clk);
        b_in_data = d; b_in_mode = m; b_in_valid = 1'b1;
        n = 0;
        while (!b_in_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        n = 0;
        while (!b_out_valid && n < 50) begin @(posedge clk); n++; #1; end
        check("b_latency", n, 32'd9);
        res = b_out_data;
        ovf = b_out_ovf;
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  d;
        logic        m;
        int          hold;
        logic [11:0] exp;
    } vec_t;

    initial begin
        vec_t        vec [6];
        logic [11:0] res;
        logic [7:0]  bres;
        logic        bovf;
        int          lat;
        int          cyc, na, no;
        int          acc_t [2];
        int          out_t [2];
        logic [11:0] out_v [2];

        vec[0] = '{8'd255, 1'b1, 0, 12'h588};
        vec[1] = '{8'd0,   1'b1, 0, 12'h333};
        vec[2] = '{8'd0,   1'b0, 0, 12'h000};
        vec[3] = '{8'd99,  1'b0, 0, 12'h099};
        vec[4] = '{8'd128, 1'b1, 5, 12'h45B};
        vec[5] = '{8'd37,  1'b0, 1, 12'h037};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {20'd0, out_data},  32'd0);
        check("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            do_conv(vec[i].d, vec[i].m, vec[i].hold, res, lat);
            check("vec_latency", lat, 32'd9);
            check("vec_data", {20'd0, res}, {20'd0, vec[i].exp});
            check("vec_ovf",  {31'd0, out_ovf}, 32'd0);
        end

        // Asynchronous reset at SHIFT cycle 4, after a non-zero prior result
        do_conv(8'd123, 1'b1, 0, res, lat);
        @(negedge clk);
        in_data = 8'd200; in_mode = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready",  {31'd0, in_ready},  32'd1);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_data",  {20'd0, out_data},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_conv(8'd37, 1'b0, 0, res, lat);
        check("arst_next_data", {20'd0, res}, 32'h037);
        check("arst_next_lat",  lat, 32'd9);

        // Back-to-back with in_valid held high and out_ready held high
        @(negedge clk);
        in_data = 8'd10; in_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0; na = 0; no = 0;
        while (no < 2 && cyc < 100) begin
            if (na == 1) in_data = 8'd11;
            if (na == 2) in_valid = 1'b0;
            if (in_valid && in_ready && na < 2) begin acc_t[na] = cyc; na++; end
            if (out_valid && out_ready) begin
                out_t[no] = cyc; out_v[no] = out_data; no++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_count", no, 32'd2);
        if (no == 2 && na == 2) begin
            check("b2b_first",  {20'd0, out_v[0]}, 32'h343);
            check("b2b_second", {20'd0, out_v[1]}, 32'h344);
            check("b2b_gap",    acc_t[1] - out_t[0], 32'd1);
            check("b2b_lat",    out_t[0] - acc_t[0], 32'd10);
        end

        // Randomised conversions against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic [7:0] d;
            logic       m;
            logic [15:0] e;
            d = 8'($urandom);
            m = 1'($urandom);
            e = ref_conv(int'(d), m, 3);
            do_conv(d, m, int'($urandom_range(0, 2)), res, lat);
            check("rnd_data", {20'd0, res}, {20'd0, e[11:0]});
            check("rnd_lat",  lat, 32'd9);
        end

        // Wrap-around with two digits
        do_conv2(8'd200, 1'b1, bres, bovf);
        check("ovf_data", {24'd0, bres}, 32'h33);
`ifdef BIN2XS3_OVF_EN
        check("ovf_flag_set", {31'd0, bovf}, 32'd1);
`endif
        do_conv2(8'd42, 1'b1, bres, bovf);
        check("ovf_next_data", {24'd0, bres}, 32'h75);
        check("ovf_flag_clr",  {31'd0, bovf}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            logic [7:0]  d;
            logic        m;
            logic [15:0] e;
            d = 8'($urandom);
            m = 1'($urandom);
            e = ref_conv(int'(d), m, 2);
            do_conv2(d, m, bres, bovf);
            check("rnd2_data", {24'd0, bres}, {24'd0, e[7:0]});
`ifdef BIN2XS3_OVF_EN
            check("rnd2_ovf", {31'd0, bovf}, {31'd0, (d >= 8'd100)});
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bin_to_xs3_seq
`default_nettype wire
